// File: rtl/openram_wb_march_master_if.sv
// Wishbone B4 classic bus bundle between the march master (initiator) and an SRAM responder.
interface openram_wb_march_master_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/openram_wb_march_master.sv
// Wishbone B4 classic initiator running a W0/R0/W1/R1 march over a word window of the SRAM.
// Build option: define MARCH_STOP_ON_FAIL_EN to end the run at the first read mismatch.
module openram_wb_march_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int unsigned NUM_WORDS      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic [31:0]                 pattern,
   openram_wb_march_master_if.master   wbm,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout,
   output logic [15:0]                 err_count,
   output logic [31:0]                 fail_addr,
   output logic [31:0]                 fail_data
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_FIN
   } state_t;

   state_t      state;
   logic [1:0]  phase;
   logic [15:0] idx;
   logic [15:0] tcnt;
   logic [31:0] pat_q;

   logic [15:0] nxt_idx;
   logic [1:0]  nxt_phase;
   logic        last_idx;
   logic        rd_miss;

   // Phases 2/3 use the complemented background.
   function automatic logic [31:0] exp_word(input logic [31:0] pat, input logic [1:0] ph,
                                            input logic [15:0] i);
      logic [31:0] e;
      e = pat ^ {16'h0000, i};
      return ph[1] ? ~e : e;
   endfunction

   function automatic logic [31:0] word_addr(input logic [15:0] i);
      return BASE_ADDR + {14'd0, i, 2'b00};
   endfunction

   function automatic logic [31:0] wr_data(input logic [31:0] pat, input logic [1:0] ph,
                                           input logic [15:0] i);
      return ph[0] ? 32'h0000_0000 : exp_word(pat, ph, i);
   endfunction

   always_comb begin
      last_idx  = (idx == LAST_IDX);
      nxt_idx   = last_idx ? 16'd0 : idx + 16'd1;
      nxt_phase = last_idx ? phase + 2'd1 : phase;
      rd_miss   = (state == ST_REQ) && wbm.wbm_ack_i && phase[0] &&
                  (wbm.wbm_dat_i != exp_word(pat_q, phase, idx));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         phase         <= 2'd0;
         idx           <= 16'd0;
         tcnt          <= 16'd0;
         pat_q         <= 32'h0;
         wbm.wbm_cyc_o <= 1'b0;
         wbm.wbm_stb_o <= 1'b0;
         wbm.wbm_we_o  <= 1'b0;
         wbm.wbm_sel_o <= 4'h0;
         wbm.wbm_adr_o <= 32'h0;
         wbm.wbm_dat_o <= 32'h0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         err_count     <= 16'h0;
         fail_addr     <= 32'h0;
         fail_data     <= 32'h0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state         <= ST_REQ;
                  phase         <= 2'd0;
                  idx           <= 16'd0;
                  tcnt          <= 16'd0;
                  pat_q         <= pattern;
                  busy          <= 1'b1;
                  pass          <= 1'b0;
                  timeout       <= 1'b0;
                  err_count     <= 16'h0;
                  fail_addr     <= 32'h0;
                  fail_data     <= 32'h0;
                  wbm.wbm_cyc_o <= 1'b1;
                  wbm.wbm_stb_o <= 1'b1;
                  wbm.wbm_we_o  <= 1'b1;
                  wbm.wbm_sel_o <= 4'hF;
                  wbm.wbm_adr_o <= word_addr(16'd0);
                  wbm.wbm_dat_o <= wr_data(pattern, 2'd0, 16'd0);
               end
            end

            ST_REQ: begin
               if (wbm.wbm_ack_i) begin
                  wbm.wbm_cyc_o <= 1'b0;
                  wbm.wbm_stb_o <= 1'b0;
                  wbm.wbm_we_o  <= 1'b0;
                  wbm.wbm_sel_o <= 4'h0;
                  wbm.wbm_dat_o <= 32'h0;
                  tcnt          <= 16'd0;
                  if (rd_miss) begin
                     if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                     if (err_count == 16'h0) begin
                        fail_addr <= word_addr(idx);
                        fail_data <= wbm.wbm_dat_i;
                     end
                  end
`ifdef MARCH_STOP_ON_FAIL_EN
                  if (rd_miss) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     pass  <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
`else
                  state <= ST_GAP;
`endif
               end else if (tcnt == TO_LAST) begin
                  // Responder never answered: abandon the cycle and report.
                  wbm.wbm_cyc_o <= 1'b0;
                  wbm.wbm_stb_o <= 1'b0;
                  wbm.wbm_we_o  <= 1'b0;
                  wbm.wbm_sel_o <= 4'h0;
                  wbm.wbm_dat_o <= 32'h0;
                  timeout       <= 1'b1;
                  pass          <= 1'b0;
                  state         <= ST_FIN;
                  done          <= 1'b1;
                  busy          <= 1'b0;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end

            ST_GAP: begin
               if (last_idx && (phase == 2'd3)) begin
                  state <= ST_FIN;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_count == 16'h0) && !timeout;
               end else begin
                  state         <= ST_REQ;
                  idx           <= nxt_idx;
                  phase         <= nxt_phase;
                  wbm.wbm_cyc_o <= 1'b1;
                  wbm.wbm_stb_o <= 1'b1;
                  wbm.wbm_we_o  <= ~nxt_phase[0];
                  wbm.wbm_sel_o <= 4'hF;
                  wbm.wbm_adr_o <= word_addr(nxt_idx);
                  wbm.wbm_dat_o <= wr_data(pat_q, nxt_phase, nxt_idx);
               end
            end

            ST_FIN: begin
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/openram_wb_march_master.md
Name: openram_wb_march_master

Overview:
- Wishbone B4 classic initiator that drives the testchip's Wishbone SRAM responder for self-test without the management core.
- Runs a 4-phase march over a contiguous word window: W0, R0, W1, R1.
- Compares each read word against the expected pattern and reports pass/fail, an error count, and the first failing address/data.
- Sits on the same clk domain as the responder; its outputs replace the management-side wbs_* drivers in bring-up benches and in the optional on-chip BIST mux.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of word 0 of the window.
- NUM_WORDS, 256, words tested per phase; range 1..65536.
- TIMEOUT_CYCLES, 255, maximum cycles stb is held without ack before abort; range 1..65535.

Ports:
- clk  input  1  block clock, shared with the Wishbone responder.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; starts a run when idle.
- pattern  input  32  seed pattern; sampled on accepted start.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  1 = write.
- wbm_sel_o  output  4  byte selects; always 4'hF during a request.
- wbm_adr_o  output  32  byte address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data; valid with ack.
- wbm_ack_i  input  1  responder acknowledge.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of run (normal or abort).
- pass  output  1  1 when the last run had no mismatch and no timeout; held until next start.
- timeout  output  1  last run aborted on missing ack; held until next start.
- err_count  output  16  number of mismatches in the run; saturates at 16'hFFFF.
- fail_addr  output  32  address of the first mismatch.
- fail_data  output  32  read data at the first mismatch.

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0, including cyc, stb, we, sel, adr, dat_o, busy, done, pass, timeout, err_count, fail_addr, fail_data. A reset mid-run aborts immediately with no done pulse.
- States: IDLE, REQ, GAP, FIN.
  - IDLE --start--> REQ. Phase=0 and index=0 are set, pattern is latched, and pass/timeout/err_count/fail_* are cleared.
  - REQ: cyc=stb=1, registered.
    - On ack, deassert cyc/stb the next cycle and go to GAP.
    - If ack has not arrived after TIMEOUT_CYCLES cycles of stb high, drop cyc/stb, set timeout=1 and pass=0, and go to FIN.
  - GAP: one idle cycle. Then increment index; at NUM_WORDS-1, wrap index to 0 and advance phase. After phase 3 go to FIN, else go to REQ.
  - FIN: done=1 for one cycle; busy falls in the same cycle; return to IDLE.
- Address: BASE_ADDR + 4*index, with 32-bit wrap-around.
- Expected data E(i) = pattern ^ {16'b0, index[15:0]} in phases 0/1, and ~(pattern ^ {16'b0, index}) in phases 2/3.
- we=1 in phases 0/2 with dat_o=E(i); we=0 in phases 1/3 with dat_o=0.
- Compare on the ack cycle of read phases. If wbm_dat_i != E(i):
  - err_count increments, saturating.
  - On the first mismatch only, capture fail_addr and fail_data.
- Ack while stb is low is ignored. Ack in the same cycle stb first rises is accepted (zero-wait responder).
- Per-transaction latency: stb high for (ack latency + 1) cycles, then 1 cycle low.
- A start pulse while busy, or during FIN, is ignored.
- pass is written at FIN: 1 iff err_count==0 and timeout==0.

Optional Feature:
- MARCH_STOP_ON_FAIL_EN defined: the first mismatch goes directly to FIN after that ack (no GAP, no further transactions). err_count=1, pass=0, timeout=0.
- Not defined: the run always completes all 4 phases (unless it times out) and counts every mismatch.

Test Plan:
- Setup: NUM_WORDS=4, BASE_ADDR=0x3000_0000, 1-cycle-latency ideal memory model.
- Clean run: pattern=0xA5A5_0000.
  - Required: 16 transactions with adr 0x3000_0000, 0x3000_0004, 0x3000_0008, 0x3000_000C per phase.
  - W0 data 0xA5A5_0000..0xA5A5_0003; W1 data 0x5A5A_FFFF..0x5A5A_FFFC.
  - Expect done once, pass=1, err_count=0, sel=4'hF throughout.
- Stuck fault: model forces bit1 of word 2 to 0.
  - Required: err_count=1 (mismatch in R0 only), fail_addr=0x3000_0008, fail_data=0xA5A5_0000, pass=0.
  - With MARCH_STOP_ON_FAIL_EN: done arrives after the 7th transaction.
- Timeout: TIMEOUT_CYCLES=16; model never acks word 1 of W0.
  - Required: stb high exactly 16 cycles, then timeout=1, pass=0, done pulse, and cyc low thereafter.
- Back-pressure: ack delayed 3 cycles on every access.
  - Required: same results as the clean run; stb held 4 cycles per access with stable adr/dat/we.
- Control robustness:
  - start pulsed again mid-run is ignored (no restart, adr sequence unchanged).
  - resetn low at transaction 9 clears all outputs asynchronously with no done pulse.
  - A fresh start after reset completes a clean run.
